// File: rtl/q_max_seq.sv
// q_max_seq
// Scans one Q-table row of N_ACTIONS single-precision entries, reading one
// entry per visit to READ and folding it into a running best through a
// shared external two-input FP max unit. The result (max Q(s',a')) is
// presented on max_val together with a one-cycle done pulse.
// Optional macro Q_MAX_ARGMAX_EN: when defined, the index of the winning
// entry is tracked and reported on max_idx; otherwise max_idx is tied to 0.

module q_max_seq #(
    parameter int N_ACTIONS = 4,
    parameter int ADDR_W    = 8,
    parameter int IDX_W     = 2,
    parameter int CMP_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              cmp_en,
    output logic [31:0]       cmp_a,
    output logic [31:0]       cmp_b,
    input  logic [31:0]       cmp_out,
    output logic [31:0]       max_val,
    output logic [IDX_W-1:0]  max_idx
);

    localparam int LAT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(N_ACTIONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(CMP_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CMP, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_r;
    logic [IDX_W-1:0]  i_r;
    logic [31:0]       best, best_n;
    logic [31:0]       cur;
    logic [LAT_W-1:0]  lat_cnt;
    logic              first_rd;
    logic              last_cmp;

    // Entry 0 seeds the running best; every later entry goes through the max unit.
    assign first_rd = (i_r == '0);
    // The max unit result is only trusted in the final cycle of the compare window.
    assign last_cmp = (state == CMP) && (lat_cnt == LAST_LAT);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_rd_en = (state == READ);
    assign cmp_en    = (state == CMP) && (lat_cnt == '0);
    assign mem_addr  = base_r + ADDR_W'(i_r);
    assign cmp_a     = best;
    assign cmp_b     = cur;

    // Next-state selection and the value the running best takes at the next edge.
    always_comb begin
        state_n = state;
        best_n  = best;
        case (state)
            IDLE: begin
                if (start) state_n = READ;
            end
            READ: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (first_rd) begin
                    best_n  = mem_rd_data;
                    state_n = (LAST_I == '0) ? DONE : READ;
                end else begin
                    state_n = CMP;
                end
            end
            CMP: begin
                if (last_cmp) begin
                    best_n  = cmp_out;
                    state_n = (i_r == LAST_I) ? DONE : READ;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register, row bookkeeping and the result register loaded on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_r  <= '0;
            i_r     <= '0;
            best    <= '0;
            cur     <= '0;
            lat_cnt <= '0;
            max_val <= '0;
        end else begin
            state <= state_n;
            best  <= best_n;
            if (state == IDLE && start) begin
                base_r <= base_addr;
                i_r    <= '0;
            end
            if (state == WAIT && !first_rd) begin
                cur <= mem_rd_data;
            end
            if (state_n == READ && state != IDLE) begin
                i_r <= i_r + IDX_ONE;
            end
            lat_cnt <= (state == CMP && !last_cmp) ? lat_cnt + LAT_ONE : '0;
            if (state_n == DONE) begin
                max_val <= best_n;
            end
        end
    end

`ifdef Q_MAX_ARGMAX_EN
    logic [IDX_W-1:0] best_idx, best_idx_n;

    // The index only moves when the max unit hands back something other than the old best, so ties keep the lower index.
    always_comb begin
        best_idx_n = best_idx;
        if (state == WAIT && first_rd) begin
            best_idx_n = '0;
        end else if (last_cmp && (cmp_out != best)) begin
            best_idx_n = i_r;
        end
    end

    // Index register and its published copy, captured alongside max_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx <= '0;
            max_idx  <= '0;
        end else begin
            best_idx <= best_idx_n;
            if (state_n == DONE) begin
                max_idx <= best_idx_n;
            end
        end
    end
`else
    assign max_idx = '0;
`endif

endmodule

// File: tb/tb_q_max_seq.sv
// tb_q_max_seq
// Drives three sequencer instances from one shared start/base_addr/rst:
//   dut0: N_ACTIONS=4, CMP_LAT=1   dut1: N_ACTIONS=1, CMP_LAT=1
//   dut2: N_ACTIONS=4, CMP_LAT=3
// Each has its own Q-memory read port and max unit emulation. A behavioural
// model computes each scan's expected row maximum, first index of the maximum,
// read addresses, compare operands and done timing from the row contents.
// Honours Q_MAX_ARGMAX_EN for the expected max_idx.

module tb_q_max_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;

    logic        busy_s      [3];
    logic        done_s      [3];
    logic        rd_en_s     [3];
    logic [7:0]  addr_s      [3];
    logic [31:0] rd_data_s   [3];
    logic        cmp_en_s    [3];
    logic [31:0] cmp_a_s     [3];
    logic [31:0] cmp_b_s     [3];
    logic [31:0] cmp_out_s   [3];
    logic [31:0] max_val_s   [3];
    logic [1:0]  max_idx_s   [3];

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;
    int edgecnt = 0;

    // behavioural model state per instance
    bit          mb       [3];
    bit          rflag    [3];
    int          cyc      [3];
    int          acc_edge [3];
    logic [7:0]  mbase    [3];
    logic [31:0] mrow     [3][4];
    logic [31:0] pre      [3][4];
    logic [31:0] exp_val  [3];
    int          exp_idx  [3];
    int          nr       [3];
    int          nc       [3];
    int          hold     [3];
    logic [31:0] ha       [3];
    logic [31:0] hb       [3];
    int          done_cnt [3];
    int          last_lat [3];
    int          last_nc  [3];
    logic [31:0] last_val [3];
    logic [1:0]  last_idx [3];
    logic [7:0]  addr_log [3][4];
    int          ph       [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    q_max_seq #(.N_ACTIONS(4), .ADDR_W(8), .IDX_W(2), .CMP_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy_s[0]), .done(done_s[0]), .mem_rd_en(rd_en_s[0]), .mem_addr(addr_s[0]),
        .mem_rd_data(rd_data_s[0]), .cmp_en(cmp_en_s[0]), .cmp_a(cmp_a_s[0]), .cmp_b(cmp_b_s[0]),
        .cmp_out(cmp_out_s[0]), .max_val(max_val_s[0]), .max_idx(max_idx_s[0]));

    q_max_seq #(.N_ACTIONS(1), .ADDR_W(8), .IDX_W(2), .CMP_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy_s[1]), .done(done_s[1]), .mem_rd_en(rd_en_s[1]), .mem_addr(addr_s[1]),
        .mem_rd_data(rd_data_s[1]), .cmp_en(cmp_en_s[1]), .cmp_a(cmp_a_s[1]), .cmp_b(cmp_b_s[1]),
        .cmp_out(cmp_out_s[1]), .max_val(max_val_s[1]), .max_idx(max_idx_s[1]));

    q_max_seq #(.N_ACTIONS(4), .ADDR_W(8), .IDX_W(2), .CMP_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy_s[2]), .done(done_s[2]), .mem_rd_en(rd_en_s[2]), .mem_addr(addr_s[2]),
        .mem_rd_data(rd_data_s[2]), .cmp_en(cmp_en_s[2]), .cmp_a(cmp_a_s[2]), .cmp_b(cmp_b_s[2]),
        .cmp_out(cmp_out_s[2]), .max_val(max_val_s[2]), .max_idx(max_idx_s[2]));

    function automatic int nfun(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic int lfun(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic int latfun(input int k);
        return 2 * nfun(k) + (nfun(k) - 1) * lfun(k) + 1;
    endfunction

    // Total order on IEEE-754 bit patterns (finite values): larger key = larger number.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] fpmax(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] pinIdx(input int i);
`ifdef Q_MAX_ARGMAX_EN
        return 32'(i);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] randFloat();
        logic [31:0] r;
        r = $urandom;
        if (r[30:23] == 8'hFF) r[30] = 1'b0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Q-memory read ports (data only valid the cycle after a read) and max unit pipeline phase.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rd_data_s[k] <= rd_en_s[k] ? mem[addr_s[k]] : 32'hBAD0_BAD0;
            ph[k] <= cmp_en_s[k] ? 1 : ((ph[k] != 0 && ph[k] < 15) ? ph[k] + 1 : 0);
        end
    end

    // Max unit: result valid only in the CMP_LAT-th cycle counted from cmp_en.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cmp_out_s[k] = (cmp_en_s[k] ? (lfun(k) == 1) : (ph[k] != 0 && ph[k] == lfun(k) - 1))
                           ? fpmax(cmp_a_s[k], cmp_b_s[k]) : 32'h7FC0_DEAD;
        end
    end

    // Behavioural model: accept, scan timeline and expected row result.
    always @(posedge clk) begin : model
        logic [31:0] bestv, v;
        int bi;
        edgecnt++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mb[k] = 1'b0;
                rflag[k] = 1'b1;
                hold[k] = 0;
            end else begin
                rflag[k] = 1'b0;
                if (mb[k]) begin
                    cyc[k]++;
                    if (cyc[k] > latfun(k)) mb[k] = 1'b0;
                end else if (start) begin
                    mb[k] = 1'b1;
                    cyc[k] = 1;
                    acc_edge[k] = edgecnt;
                    mbase[k] = base_addr;
                    nr[k] = 0;
                    nc[k] = 0;
                    hold[k] = 0;
                    bestv = 32'h0;
                    bi = 0;
                    for (int j = 0; j < nfun(k); j++) begin
                        v = mem[8'(base_addr + 8'(j))];
                        mrow[k][j] = v;
                        if (j == 0) begin
                            bestv = v;
                        end else begin
                            pre[k][j] = bestv;
                            if (fkey(v) > fkey(bestv)) begin
                                bestv = v;
                                bi = j;
                            end
                        end
                    end
                    exp_val[k] = bestv;
                    exp_idx[k] = bi;
                end
            end
        end
    end

    // Compare process: every cycle, every instance, against the model.
    always @(negedge clk) begin
        if (edgecnt > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (done_s[k] === 1'b1) done_cnt[k]++;
                if (rflag[k]) begin
                    checkOutput($sformatf("d%0d_rst_busy", k), busy_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_done", k), done_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_rd_en", k), rd_en_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_cmp_en", k), cmp_en_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_addr", k), addr_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_cmp_a", k), cmp_a_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_cmp_b", k), cmp_b_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_max_val", k), max_val_s[k], 0);
                    checkOutput($sformatf("d%0d_rst_max_idx", k), max_idx_s[k], 0);
                end else begin
                    checkOutput($sformatf("d%0d_busy", k), busy_s[k], mb[k]);
                    checkOutput($sformatf("d%0d_done", k), done_s[k], (mb[k] && cyc[k] == latfun(k)));
                    if (!mb[k]) begin
                        checkOutput($sformatf("d%0d_idle_rd_en", k), rd_en_s[k], 0);
                        checkOutput($sformatf("d%0d_idle_cmp_en", k), cmp_en_s[k], 0);
                    end else begin
                        if (rd_en_s[k] === 1'b1) begin
                            checkOutput($sformatf("d%0d_addr", k), addr_s[k], 8'(mbase[k] + 8'(nr[k])));
                            if (nr[k] < 4) addr_log[k][nr[k]] = addr_s[k];
                            nr[k]++;
                        end
                        if (cmp_en_s[k] === 1'b1) begin
                            nc[k]++;
                            if (nc[k] < nfun(k)) begin
                                checkOutput($sformatf("d%0d_cmp_a", k), cmp_a_s[k], pre[k][nc[k]]);
                                checkOutput($sformatf("d%0d_cmp_b", k), cmp_b_s[k], mrow[k][nc[k]]);
                            end
                            ha[k] = cmp_a_s[k];
                            hb[k] = cmp_b_s[k];
                            hold[k] = lfun(k) - 1;
                        end else if (hold[k] > 0) begin
                            checkOutput($sformatf("d%0d_cmp_a_hold", k), cmp_a_s[k], ha[k]);
                            checkOutput($sformatf("d%0d_cmp_b_hold", k), cmp_b_s[k], hb[k]);
                            hold[k]--;
                        end
                        if (done_s[k] === 1'b1 && cyc[k] == latfun(k)) begin
                            checkOutput($sformatf("d%0d_max_val", k), max_val_s[k], exp_val[k]);
                            checkOutput($sformatf("d%0d_max_idx", k), max_idx_s[k], pinIdx(exp_idx[k]));
                            checkOutput($sformatf("d%0d_reads", k), nr[k], nfun(k));
                            checkOutput($sformatf("d%0d_cmps", k), nc[k], nfun(k) - 1);
                            last_val[k] = max_val_s[k];
                            last_idx[k] = max_idx_s[k];
                            last_nc[k]  = nc[k];
                            last_lat[k] = edgecnt - acc_edge[k] + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic loadRow(input logic [7:0] base, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        mem[base]             = v0;
        mem[8'(base + 8'd1)]  = v1;
        mem[8'(base + 8'd2)]  = v2;
        mem[8'(base + 8'd3)]  = v3;
    endtask

    task automatic waitIdle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!mb[0] && !mb[1] && !mb[2]) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_idle"}, ok, 1);
    endtask

    // One start pulse at the given base, then let every instance finish.
    task automatic applyStimulus(input logic [7:0] base, input string tag);
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle(tag);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] vals [4];
        int dbefore, cnt;
        bit got;

        rst = 1'b1;
        start = 1'b0;
        base_addr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = randFloat();
        repeat (3) @(negedge clk);
        checkOutput("reset_max_val", max_val_s[0], 0);
        checkOutput("reset_busy", busy_s[0], 0);
        rst = 1'b0;
        @(negedge clk);

        // basic row
        loadRow(8'h10, 32'h3F800000, 32'h40200000, 32'hC0400000, 32'h3F000000);
        applyStimulus(8'h10, "s1");
        checkOutput("s1_max_val", last_val[0], 32'h40200000);
        checkOutput("s1_max_idx", last_idx[0], pinIdx(1));
        checkOutput("s1_latency", last_lat[0], 12);
        checkOutput("s1_cmp_pulses", last_nc[0], 3);
        checkOutput("s1_addr0", addr_log[0][0], 8'h10);
        checkOutput("s1_addr3", addr_log[0][3], 8'h13);
        checkOutput("s1_n1_max_val", last_val[1], 32'h3F800000);
        checkOutput("s1_lat3_max_val", last_val[2], 32'h40200000);
        checkOutput("s1_lat3_latency", last_lat[2], 18);

        // all negative
        loadRow(8'h50, 32'hBF800000, 32'hBF000000, 32'hC0400000, 32'hC0000000);
        applyStimulus(8'h50, "s2");
        checkOutput("s2_max_val", last_val[0], 32'hBF000000);
        checkOutput("s2_max_idx", last_idx[0], pinIdx(1));

        // ties keep the lowest index
        loadRow(8'h60, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000);
        applyStimulus(8'h60, "s3");
        checkOutput("s3_max_val", last_val[0], 32'h40000000);
        checkOutput("s3_max_idx", last_idx[0], pinIdx(0));
        checkOutput("s3_lat3_max_idx", last_idx[2], pinIdx(0));

        // start held high with a mid-scan re-pulse, then restart at 0xFE right after DONE
        loadRow(8'h20, 32'hBF800000, 32'hBF000000, 32'hC0400000, 32'hC0000000);
        loadRow(8'hFE, 32'h3F000000, 32'hBF800000, 32'h40400000, 32'h40400000);
        @(negedge clk);
        dbefore = done_cnt[0];
        base_addr = 8'h20;
        start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (c == 4) start = 1'b0;
            if (c == 5) start = 1'b1;
        end
        checkOutput("s4_done_seen", got, 1);
        base_addr = 8'hFE;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("s4_single_done", done_cnt[0] - dbefore, 1);
        checkOutput("s4_max_val", last_val[0], 32'hBF000000);
        waitIdle("s4");
        checkOutput("s4_wrap_addr0", addr_log[0][0], 8'hFE);
        checkOutput("s4_wrap_addr1", addr_log[0][1], 8'hFF);
        checkOutput("s4_wrap_addr2", addr_log[0][2], 8'h00);
        checkOutput("s4_wrap_addr3", addr_log[0][3], 8'h01);
        checkOutput("s4_wrap_max_val", last_val[0], 32'h40400000);
        checkOutput("s4_wrap_max_idx", last_idx[0], pinIdx(2));

        // reset in the second CMP cycle, then a clean scan
        loadRow(8'h30, 32'h40A00000, 32'h3F800000, 32'h40C00000, 32'hC1200000);
        @(negedge clk);
        base_addr = 8'h30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cmp_en_s[0] === 1'b1) cnt++;
            if (cnt == 2) begin
                rst = 1'b1;
                got = 1'b1;
                break;
            end
        end
        checkOutput("s5_second_cmp_seen", got, 1);
        @(negedge clk);
        checkOutput("s5_rst_max_val", max_val_s[0], 0);
        checkOutput("s5_rst_done", done_s[0], 0);
        rst = 1'b0;
        waitIdle("s5_rst");
        applyStimulus(8'h30, "s5");
        checkOutput("s5_max_val", last_val[0], 32'h40C00000);
        checkOutput("s5_max_idx", last_idx[0], pinIdx(2));

        // single-entry row
        loadRow(8'h70, 32'hC0400000, 32'h41000000, 32'h41100000, 32'h41200000);
        applyStimulus(8'h70, "s6");
        checkOutput("s6_n1_max_val", last_val[1], 32'hC0400000);
        checkOutput("s6_n1_max_idx", last_idx[1], 0);
        checkOutput("s6_n1_latency", last_lat[1], 3);
        checkOutput("s6_n1_cmp_pulses", last_nc[1], 0);

        // randomized rows, bases and gaps
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < 4; j++) begin
                if (j > 0 && $urandom_range(0, 2) == 0) vals[j] = vals[$urandom_range(0, j - 1)];
                else vals[j] = randFloat();
            end
            base_addr = 8'($urandom);
            loadRow(base_addr, vals[0], vals[1], vals[2], vals[3]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(base_addr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_max_seq.md
Name: q_max_seq

Overview:
- Sequencer that finds the maximum Q-value, and optionally its action index, across one Q-table row of N_ACTIONS IEEE-754 single-precision entries.
- Reads entries one at a time from a Q-memory read port.
- Time-shares a single external two-input FP max unit (max_2_fp-style) for every pairwise compare.
- Sits between the Q-table RAM and the Q-update datapath; supplies max Q(s', a') for the Bellman update.

Parameters:
- N_ACTIONS, 4, number of entries per row; must be >= 1.
- ADDR_W, 8, Q-memory address width.
- IDX_W, 2, action index width; must satisfy 2^IDX_W >= N_ACTIONS.
- CMP_LAT, 1, cycles from cmp_en assertion to cmp_out being valid; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a row scan; sampled only in IDLE.
- base_addr  in  ADDR_W  address of action 0 of the row; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when max_val/max_idx are valid.
- mem_rd_en  out  1  Q-memory read strobe.
- mem_addr  out  ADDR_W  Q-memory read address.
- mem_rd_data  in  32  Q-memory read data, valid exactly 1 cycle after mem_rd_en.
- cmp_en  out  1  one-cycle strobe to the shared max unit.
- cmp_a  out  32  running best value; held for all CMP_LAT cycles.
- cmp_b  out  32  candidate value; held for all CMP_LAT cycles.
- cmp_out  in  32  max(cmp_a, cmp_b) from the max unit.
- max_val  out  32  result maximum; holds until the next accepted start.
- max_idx  out  IDX_W  index of max_val (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal best, cur, i and the latency counter cleared. Reset mid-scan aborts the scan with no done pulse; the next start after reset runs normally.
- FSM states: IDLE, READ, WAIT, CMP, DONE.
- IDLE: start=1 latches base_addr, sets i=0, goes to READ. start is ignored in every other state; no queuing.
- READ (1 cycle): mem_rd_en=1, mem_addr=base_addr+i (modulo 2^ADDR_W wrap). Go to WAIT.
- WAIT (1 cycle): latch mem_rd_data.
  - If i==0: best=data, best_idx=0; then go to READ with i=1, or to DONE if N_ACTIONS==1.
  - If i>0: cur=data; go to CMP.
- CMP (CMP_LAT cycles): cmp_en=1 in the first cycle only. cmp_a=best and cmp_b=cur are stable throughout. On the edge ending the last CMP cycle, sample cmp_out into best.
  - If cmp_out differs bitwise from the old best, best_idx=i. Ties keep the lower index.
  - Then i==N_ACTIONS-1 goes to DONE; otherwise i++ and go to READ.
- DONE (1 cycle): done=1; max_val=best and max_idx=best_idx are registered on entry. Next state IDLE; start may be accepted on the cycle after DONE.
- cmp_a, cmp_b and mem_addr hold their last values outside active states; mem_rd_en and cmp_en are 0.
- Latency: done asserts exactly 2*N_ACTIONS + (N_ACTIONS-1)*CMP_LAT + 1 cycles after the edge that samples start.
  - N=4, CMP_LAT=1: 12 cycles.
  - N=1: 3 cycles.
- Exactly N_ACTIONS reads and N_ACTIONS-1 cmp_en pulses per scan.
- The block performs no FP arithmetic itself; NaN and ±0 ordering is whatever the max unit returns.

Optional Feature:
- Macro: Q_MAX_ARGMAX_EN.
- Defined: best_idx is tracked as described and max_idx reports it.
- Undefined: no index register or bitwise-compare logic is built; max_idx is tied to 0. max_val and all timing are unchanged.

Test Plan:
- Behavioural max model (CMP_LAT=1), N=4, row [3F800000, 40200000, C0400000, 3F000000] at base 0x10 -> reads at 0x10..0x13, 3 cmp_en pulses, done 12 cycles after start, max_val=40200000, max_idx=1.
- All-negative row [BF800000, BF000000, C0400000, C0000000] -> max_val=BF000000, max_idx=1.
- Tie row [40000000, 40000000, 3F800000, 40000000] -> max_val=40000000, max_idx=0.
- start held high during a scan, plus a second start pulse mid-scan -> exactly one scan and one done pulse. Re-start on the cycle after DONE, with base_addr=0xFE, N=4 -> addresses FE, FF, 00, 01.
- rst asserted in the second CMP cycle -> next edge: all outputs 0, IDLE, no done. A following start yields a correct full result.
- N_ACTIONS=1, row [C0400000] -> zero cmp_en pulses, done 3 cycles after start, max_val=C0400000, max_idx=0. With Q_MAX_ARGMAX_EN undefined, rerun the first scenario -> max_idx=0, max_val unchanged.
